hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit.sv | 127 ++++++++++++
 tb/tb_hazard_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
`default_nettype none
//==============================================================================
// Module  : hazard_unit
// Purpose : Pipeline hazard controller. It handles load-use stalls, branch
//           flushes and data-memory freezes, and it keeps a saturating
//           stall counter and a sticky memory-timeout flag.
// Revision: 1.0  initial release
//==============================================================================
module hazard_unit #(
    parameter int REG_W   = 3,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rsrc1,
    input  logic [REG_W-1:0] id_rsrc2,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic [REG_W-1:0] ex_rdst,
    input  logic             ex_mem_read,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             idex_stall,
    output logic             exmem_stall,
    output logic             idex_bubble,
    output logic             memwb_bubble,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             mem_timeout,
    output logic [1:0]       hz_state
);

    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        RUN        = 2'b00,
        MEM_WAIT   = 2'b01,
        LOAD_STALL = 2'b10,
        FLUSH      = 2'b11
    } state_t;

    state_t            state, state_nxt;
    logic              pend_flush;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic              lu, br_eff, lu_eff;
    logic              frz, fls, lus;

    assign lu = ex_mem_read & ((id_use1 & (id_rsrc1 == ex_rdst)) |
                               (id_use2 & (id_rsrc2 == ex_rdst)));

    // Per-state masking of the hazard sources, then one shared priority rule
    always_comb begin
        br_eff    = 1'b0;
        lu_eff    = 1'b0;
        frz       = 1'b0;
        fls       = 1'b0;
        lus       = 1'b0;
        state_nxt = RUN;
        case (state)
            RUN:        begin br_eff = branch_taken;              lu_eff = lu; end
            MEM_WAIT:   begin br_eff = branch_taken | pend_flush; lu_eff = lu; end
            LOAD_STALL: begin br_eff = branch_taken;              lu_eff = 1'b0; end
            default:    begin br_eff = 1'b0;                      lu_eff = 1'b0; end
        endcase
        if (mem_busy) begin
            frz       = 1'b1;
            state_nxt = MEM_WAIT;
        end else if (br_eff) begin
            fls       = 1'b1;
            state_nxt = FLUSH;
        end else if (lu_eff) begin
            lus       = 1'b1;
            state_nxt = LOAD_STALL;
        end
    end

    // Outputs are forced quiet while reset is held, whatever the inputs do
    always_comb begin
        pc_stall     = ~rst & (frz | lus);
        ifid_stall   = ~rst & (frz | lus);
        idex_stall   = ~rst & frz;
        exmem_stall  = ~rst & frz;
        memwb_bubble = ~rst & frz;
        idex_bubble  = ~rst & lus;
        ifid_flush   = ~rst & fls;
        idex_flush   = ~rst & fls;
        hz_state     = state;
    end

    // Wait counter tracks consecutive busy cycles, saturating at TIMEOUT
    always_comb begin
        wait_nxt = '0;
        if (mem_busy)
            wait_nxt = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + 1'b1;
    end

    // State, pending-flush, wait, stall and timeout registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            pend_flush  <= 1'b0;
            wait_cnt    <= '0;
            stall_cnt   <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            // A branch seen while frozen is remembered; it is replayed on the
            // first unfrozen cycle and cleared on that edge
            if (mem_busy && branch_taken)
                pend_flush <= 1'b1;
            else if (!mem_busy)
                pend_flush <= 1'b0;
            if (mem_busy && (wait_nxt == WAIT_MAX))
                mem_timeout <= 1'b1;
            if (pc_stall && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
//==============================================================================
// Module  : tb_hazard_unit
// Purpose : Directed scoreboard bench for hazard_unit.
// Revision: 1.0  initial release
//==============================================================================
module tb_hazard_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  id_rsrc1 = '0, id_rsrc2 = '0, ex_rdst = '0;
    logic        id_use1 = 1'b0, id_use2 = 1'b0, ex_mem_read = 1'b0;
    logic        branch_taken = 1'b0, mem_busy = 1'b0;
    logic        pc_stall, ifid_stall, idex_stall, exmem_stall;
    logic        idex_bubble, memwb_bubble, ifid_flush, idex_flush;
    logic [15:0] stall_cnt;
    logic        mem_timeout;
    logic [1:0]  hz_state;

    hazard_unit #(.REG_W(3), .CNT_W(16), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .id_rsrc1(id_rsrc1), .id_rsrc2(id_rsrc2),
        .id_use1(id_use1), .id_use2(id_use2),
        .ex_rdst(ex_rdst), .ex_mem_read(ex_mem_read),
        .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall),
        .idex_stall(idex_stall), .exmem_stall(exmem_stall),
        .idex_bubble(idex_bubble), .memwb_bubble(memwb_bubble),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .stall_cnt(stall_cnt), .mem_timeout(mem_timeout), .hz_state(hz_state)
    );

    always #5 clk = ~clk;

    // Control byte order: pc, ifid, idex, exmem, idex_bub, memwb_bub, ifid_fl, idex_fl
    localparam logic [7:0] NON = 8'b0000_0000;
    localparam logic [7:0] FRZ = 8'b1111_0100;
    localparam logic [7:0] LUS = 8'b1100_1000;
    localparam logic [7:0] FLS = 8'b0000_0011;

    typedef struct packed {
        logic [7:0]  ctrl;
        logic [1:0]  st;
        logic [15:0] cnt;
        logic        to;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    // Apply one cycle of stimulus just after the rising edge and queue the
    // hand-computed response for that cycle
    task automatic step(input logic r, input logic [2:0] s1, input logic u1,
                        input logic [2:0] s2, input logic u2, input logic [2:0] rd,
                        input logic mr, input logic br, input logic mb,
                        input logic [7:0] ctrl, input logic [1:0] st,
                        input logic [15:0] cnt, input logic to);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; id_rsrc1 = s1; id_use1 = u1; id_rsrc2 = s2; id_use2 = u2;
        ex_rdst = rd; ex_mem_read = mr; branch_taken = br; mem_busy = mb;
        e.ctrl = ctrl; e.st = st; e.cnt = cnt; e.to = to;
        q.push_back(e);
    endtask

    task automatic idle(input logic [7:0] ctrl, input logic [1:0] st,
                        input logic [15:0] cnt, input logic to);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, ctrl, st, cnt, to);
    endtask

    task automatic busy(input logic br, input logic [1:0] st,
                        input logic [15:0] cnt, input logic to);
        step(0, 0, 0, 0, 0, 0, 0, br, 1, FRZ, st, cnt, to);
    endtask

    // Monitor: compare on the falling edge, well away from the active edge
    initial begin
        exp_t e;
        logic [7:0] act;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {pc_stall, ifid_stall, idex_stall, exmem_stall,
                       idex_bubble, memwb_bubble, ifid_flush, idex_flush};
                n_checks++;
                if (act !== e.ctrl) begin
                    n_fails++;
                    $display("FAIL ctrl t=%0t actual=%b required=%b", $time, act, e.ctrl);
                end
                n_checks++;
                if (hz_state !== e.st) begin
                    n_fails++;
                    $display("FAIL hz_state t=%0t actual=%b required=%b", $time, hz_state, e.st);
                end
                n_checks++;
                if (stall_cnt !== e.cnt) begin
                    n_fails++;
                    $display("FAIL stall_cnt t=%0t actual=%0d required=%0d", $time, stall_cnt, e.cnt);
                end
                n_checks++;
                if (mem_timeout !== e.to) begin
                    n_fails++;
                    $display("FAIL mem_timeout t=%0t actual=%b required=%b", $time, mem_timeout, e.to);
                end
            end
        end
    end

    initial begin
        // Reset held with every hazard source active: outputs stay quiet
        step(1, 3'd3, 1, 3'd0, 0, 3'd3, 1, 1, 1, NON, 2'b00, 16'd0, 0);
        idle(NON, 2'b00, 16'd0, 0);

        // Load-use on rsrc1, then one ignored cycle in LOAD_STALL
        step(0, 3'd3, 1, 3'd0, 0, 3'd3, 1, 0, 0, LUS, 2'b00, 16'd0, 0);
        step(0, 3'd3, 1, 3'd0, 0, 3'd3, 1, 0, 0, NON, 2'b10, 16'd1, 0);
        idle(NON, 2'b00, 16'd1, 0);
        // Addresses match but neither use bit set: no stall
        step(0, 3'd3, 0, 3'd3, 0, 3'd3, 1, 0, 0, NON, 2'b00, 16'd1, 0);
        // Load-use through rsrc2
        step(0, 3'd5, 1, 3'd6, 1, 3'd6, 1, 0, 0, LUS, 2'b00, 16'd1, 0);
        idle(NON, 2'b10, 16'd2, 0);
        idle(NON, 2'b00, 16'd2, 0);

        // Three-cycle freeze with a branch in the middle, replayed afterwards
        busy(0, 2'b00, 16'd2, 0);
        busy(1, 2'b01, 16'd3, 0);
        busy(0, 2'b01, 16'd4, 0);
        idle(FLS, 2'b01, 16'd5, 0);
        // FLUSH ignores branch and load-use
        step(0, 3'd3, 1, 3'd0, 0, 3'd3, 1, 1, 0, NON, 2'b11, 16'd5, 0);
        idle(NON, 2'b00, 16'd5, 0);

        // All three hazards at once: freeze wins, branch replays on exit
        step(0, 3'd3, 1, 3'd0, 0, 3'd3, 1, 1, 1, FRZ, 2'b00, 16'd5, 0);
        idle(FLS, 2'b01, 16'd6, 0);
        idle(NON, 2'b11, 16'd6, 0);
        idle(NON, 2'b00, 16'd6, 0);

        // Branch taken while in LOAD_STALL still flushes
        step(0, 3'd2, 1, 3'd0, 0, 3'd2, 1, 0, 0, LUS, 2'b00, 16'd6, 0);
        step(0, 3'd2, 1, 3'd0, 0, 3'd2, 1, 1, 0, FLS, 2'b10, 16'd7, 0);
        idle(NON, 2'b11, 16'd7, 0);
        idle(NON, 2'b00, 16'd7, 0);

        // Ten busy cycles: timeout visible after the eighth, then sticky
        for (int k = 1; k <= 10; k++)
            busy(0, (k == 1) ? 2'b00 : 2'b01, 16'(6 + k), (k >= 9) ? 1'b1 : 1'b0);
        idle(NON, 2'b01, 16'd17, 1);
        idle(NON, 2'b00, 16'd17, 1);

        // Reset mid-freeze with a pending flush: cleared, no later flush
        busy(1, 2'b00, 16'd17, 1);
        busy(0, 2'b01, 16'd18, 1);
        step(1, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 1, NON, 2'b00, 16'd0, 0);
        idle(NON, 2'b00, 16'd0, 0);
        idle(NON, 2'b00, 16'd0, 0);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && q.size() > 0; i++)
            @(posedge clk);
        if (q.size() > 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL drain actual=%0d pending required=0", q.size());
        end
        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
